// File: rtl/cpu_pkg.sv
// Shared CPU definitions: load FSM encoding and datapath defaults.
package cpu_pkg;

    localparam int WORD_W             = 16;
    localparam int LD_TIMEOUT_DEFAULT = 15;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        REQ  = 2'b01,
        DONE = 2'b10,
        ERR  = 2'b11
    } ld_state_t;

endpackage

// File: rtl/ld_timeout_ctr.sv
// Bounded-wait cycle counter for memory handshakes.
// tc flags the last permitted wait cycle (count == LIMIT-1).
module ld_timeout_ctr #(
    parameter int LIMIT = 15
) (
    input  logic clk,
    input  logic rst,
    input  logic clear,
    input  logic enable,
    output logic tc
);

    localparam int CW = $clog2(LIMIT + 1);
    localparam logic [CW-1:0] LAST = CW'(LIMIT - 1);

    logic [CW-1:0] count_reg;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst)
            count_reg <= '0;
        else if (clear)
            count_reg <= '0;
        else if (enable)
            count_reg <= count_reg + CW'(1);
    end

    assign tc = (count_reg == LAST);

endmodule

// File: rtl/load_unit16.sv
// LOAD execution unit: fetches one word over a req/ack memory bus and
// hands it to the register file as a single-cycle write strobe.
module load_unit16
    import cpu_pkg::*;
#(
    parameter int ADDR_W  = 16,
    parameter int DATA_W  = WORD_W,
    parameter int TIMEOUT = LD_TIMEOUT_DEFAULT
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [ADDR_W-1:0] addr_in,
    output logic              mem_req,
    output logic [ADDR_W-1:0] mem_addr,
    input  logic              mem_ack,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic [DATA_W-1:0] rd_data,
    output logic              rd_valid,
    output logic              busy,
    output logic              error
);

    ld_state_t state_reg;
    logic      cnt_clear;
    logic      cnt_enable;
    logic      cnt_tc;

    assign cnt_clear  = (state_reg == IDLE) && start;
    assign cnt_enable = (state_reg == REQ) && !mem_ack && !cnt_tc;

    ld_timeout_ctr #(
        .LIMIT (TIMEOUT)
    ) u_timeout (
        .clk    (clk),
        .rst    (rst),
        .clear  (cnt_clear),
        .enable (cnt_enable),
        .tc     (cnt_tc)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_reg <= IDLE;
            mem_req   <= 1'b0;
            mem_addr  <= '0;
            rd_data   <= '0;
            rd_valid  <= 1'b0;
            busy      <= 1'b0;
            error     <= 1'b0;
        end else begin
            case (state_reg)
                IDLE: begin
                    if (start) begin
                        mem_addr  <= addr_in;
                        mem_req   <= 1'b1;
                        busy      <= 1'b1;
                        state_reg <= REQ;
                    end
                end
                REQ: begin
                    // A response on the final wait cycle still counts as success.
                    if (mem_ack) begin
                        rd_data   <= mem_rdata;
                        mem_req   <= 1'b0;
                        rd_valid  <= 1'b1;
                        state_reg <= DONE;
                    end else if (cnt_tc) begin
                        mem_req   <= 1'b0;
                        error     <= 1'b1;
                        state_reg <= ERR;
                    end
                end
                DONE: begin
                    rd_valid  <= 1'b0;
                    busy      <= 1'b0;
                    state_reg <= IDLE;
                end
                ERR: begin
                    error     <= 1'b0;
                    busy      <= 1'b0;
                    state_reg <= IDLE;
                end
                default: state_reg <= IDLE;
            endcase
        end
    end

endmodule

// File: doc/load_unit16.md
Name: load_unit16

Overview:
- Reader-side counterpart to the 16-bit register write (MOV) path. Executes a LOAD: given an address, it reads one 16-bit word from the data-memory bus over a req/ack handshake.
- Presents the word to the register file as a one-cycle write strobe.
- Sits between the control unit (start/busy/done) and the memory bus, with a bounded-wait timeout.

Parameters:
ADDR_W, 16, memory address width
DATA_W, 16, data word width
TIMEOUT, 15, max cycles waiting for mem_ack before abort (1..255)

Ports:
clk  input  1  clock, rising edge
rst  input  1  reset, asynchronous, active-low
start  input  1  begin load; sampled only in IDLE
addr_in  input  ADDR_W  load address, captured on accepted start
mem_req  output  1  memory read request
mem_addr  output  ADDR_W  registered address driven to memory
mem_ack  input  1  memory has valid data on mem_rdata this cycle
mem_rdata  input  DATA_W  read data
rd_data  output  DATA_W  loaded word (register-file write data)
rd_valid  output  1  one-cycle write strobe to register file
busy  output  1  high from accepted start until return to IDLE
error  output  1  one-cycle pulse on timeout abort

Behaviour:
- Reset (rst=0, async): state=IDLE. mem_req=0, mem_addr=0, rd_data=0, rd_valid=0, busy=0, error=0, timeout counter=0. Reset mid-transaction drops mem_req immediately; a late mem_ack after reset release is ignored.
- All outputs are registered.
- FSM states: IDLE, REQ, DONE, ERR.
- IDLE:
  - On start=1: capture mem_addr<=addr_in, mem_req<=1, busy<=1, cnt<=0; go to REQ.
  - start is ignored in any other state, with no queueing.
- REQ:
  - mem_req held at 1 and mem_addr held stable until ack or abort.
  - If mem_ack=1: rd_data<=mem_rdata, mem_req<=0, rd_valid<=1; go to DONE.
  - Else if cnt==TIMEOUT-1: mem_req<=0, error<=1; go to ERR.
  - Else cnt<=cnt+1.
  - If mem_ack and the timeout terminal count coincide, ack wins (data accepted, no error).
- DONE: rd_valid<=0, busy<=0; go to IDLE.
- ERR: error<=0, busy<=0; rd_data keeps its previous value; go to IDLE.
- Latency:
  - start accepted at edge N, so mem_req is high after N.
  - Zero-wait ack sampled at edge N+1 gives rd_valid high for the cycle after N+1.
  - busy falls after N+2.
  - Minimum start-to-start spacing is 3 cycles. A start arriving while busy=1 is lost; the controller must wait for busy=0.
- mem_ack while in IDLE, DONE or ERR: ignored, no state change.
- rd_valid and error are never high together.
- Counter width is ceil(log2(TIMEOUT+1)). It never wraps, because the abort occurs first.

Decomposition:
- Shared package cpu_pkg holds:
  - state enum ld_state_t {IDLE, REQ, DONE, ERR}, 2-bit encoding 00/01/10/11;
  - constants WORD_W=16 and LD_TIMEOUT_DEFAULT=15.
- One sub-module is natural: ld_timeout_ctr (clear, enable, terminal-count output), reusable by a future store unit.
- Everything else stays flat in load_unit16.

Test Plan:
- Reset, then start=1 with addr_in=16'h0040; memory acks the next cycle with mem_rdata=16'hA5F0 -> mem_addr=16'h0040 while mem_req=1; rd_data=16'hA5F0; rd_valid high exactly 1 cycle; busy low 3 cycles after start.
- addr_in=16'h1234; ack after 5 wait cycles with data 16'hFFFF -> mem_req high 6 cycles, mem_addr stable throughout, rd_data=16'hFFFF, error=0.
- addr_in=16'h0002; ack never asserted -> mem_req drops after 15 cycles; error pulses 1 cycle; rd_valid=0; rd_data unchanged from the prior load (16'hFFFF).
- Ack arrives exactly at the 15th wait cycle with data 16'h0001 -> rd_data=16'h0001, rd_valid=1, error=0 (ack wins).
- start pulsed again while busy=1 with addr_in=16'h00FF -> ignored; mem_addr keeps its original value; only one rd_valid pulse.
- rst driven low mid-REQ (after 3 wait cycles) -> mem_req, busy and rd_data=0 immediately; a mem_ack after rst=1 produces no rd_valid.
